// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD scan display:
//   state_e      - scan controller state (IDLE / SCAN)
//   NUM_DIGITS   - number of multiplexed digit positions (units, tens, hundreds)
//   SEG_0..SEG_9 - active-high gfedcba patterns for decimal digits
//   SEG_BLANK    - all segments off
//   SEG_E        - pattern shown for a non-BCD nibble
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int unsigned NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;

endpackage

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational nibble to 7-segment decoder (active-high, gfedcba).
//   digit_i [3:0] : nibble to show; values above 9 decode to 'E'
//   blank_i       : 1 forces all segments off
//   seg_o   [6:0] : segment pattern
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_E;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// ---------------------------------------------------------------------------
// bcd_scan_display
// Captures a 3-digit BCD result ({carry, tens, units}) and scans it onto a
// multiplexed 7-segment display with leading-zero blanking.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : upstream result available
//   in_ready        : result accepted this cycle (IDLE, or last cycle of frame)
//   sum_in  [7:0]   : packed BCD sum, [7:4] tens, [3:0] units
//   cout_in         : BCD carry = hundreds digit
//   seg     [6:0]   : registered segment pattern (gfedcba, polarity by param)
//   an      [2:0]   : registered one-hot digit enable (bit0 units)
//   err             : held value contains a nibble greater than 9
//   blank           : synchronous clear back to IDLE
// Parameters: SCAN_DIV (cycles per digit slot, >= 1), SEG_ACTIVE_LOW.
// ---------------------------------------------------------------------------
module bcd_scan_display
    import bcd_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            sum_in,
    input  logic                  cout_in,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  err,
    input  logic                  blank
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [1:0]            SLOT_LAST  = 2'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_POL    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_e                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [1:0]            slot_q, slot_d;
    logic [8:0]            hold_q, hold_d;
    logic                  err_q, err_d;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  frame_end;
    logic                  xfer;
    logic [3:0]            digit;
    logic                  digit_blank;
    logic [6:0]            seg_raw;

    assign frame_end = (state_q == SCAN) && (slot_q == SLOT_LAST) && (presc_q == PRESC_LAST);
    assign xfer      = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: blank outranks a simultaneous transfer
    always_comb begin
        state_d = state_q;
        if (blank) begin
            state_d = IDLE;
        end else if (xfer) begin
            state_d = SCAN;
        end
    end

    // Prescaler, slot counter, hold register and error flag
    always_comb begin
        presc_d = presc_q;
        slot_d  = slot_q;
        hold_d  = hold_q;
        err_d   = err_q;
        if (blank) begin
            presc_d = '0;
            slot_d  = '0;
            err_d   = 1'b0;
        end else if (xfer) begin
            presc_d = '0;
            slot_d  = '0;
            hold_d  = {cout_in, sum_in};
            err_d   = (sum_in[7:4] > 4'd9) || (sum_in[3:0] > 4'd9);
        end else if (state_q == SCAN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                slot_d  = (slot_q == SLOT_LAST) ? 2'd0 : slot_q + 2'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            slot_q  <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // Output logic: digit selection with leading-zero blanking. A pending
    // blank request clears the pins on the same edge the state returns to IDLE.
    always_comb begin
        in_ready    = rst || (state_q == IDLE) || frame_end;
        digit       = '0;
        digit_blank = 1'b1;
        if (!blank && state_q == SCAN) begin
            case (slot_q)
                2'd0: begin
                    digit       = hold_q[3:0];
                    digit_blank = 1'b0;
                end
                2'd1: begin
                    digit       = hold_q[7:4];
                    digit_blank = !hold_q[8] && (hold_q[7:4] == 4'd0);
                end
                2'd2: begin
                    digit       = {3'b000, hold_q[8]};
                    digit_blank = !hold_q[8];
                end
                default: begin
                    digit       = '0;
                    digit_blank = 1'b1;
                end
            endcase
        end
        an_d = digit_blank ? '0 : (AN_ONE << slot_q);
    end

    bcd_to_seg7 u_seg7 (
        .digit_i (digit),
        .blank_i (digit_blank),
        .seg_o   (seg_raw)
    );

    // Output register; polarity is applied here only
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK ^ SEG_POL;
            an_q  <= '0;
        end else begin
            seg_q <= seg_raw ^ SEG_POL;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst, in_valid, cout_in, blank;
    logic [7:0] sum_in;

    logic       rdy0, rdy1, err0, err1;
    logic [6:0] seg0, seg1;
    logic [2:0] an0, an1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: active-low segments, one cycle per slot.
    bcd_scan_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .sum_in(sum_in), .cout_in(cout_in), .seg(seg0), .an(an0),
        .err(err0), .blank(blank)
    );

    bcd_scan_display #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .sum_in(sum_in), .cout_in(cout_in), .seg(seg1), .an(an1),
        .err(err1), .blank(blank)
    );

    // Reference model: per instance, the captured digits and the number of
    // cycles elapsed since the capture; frame position follows by arithmetic.
    int         m_div[2] = '{4, 1};
    bit         m_al[2]  = '{1'b0, 1'b1};
    bit         m_scan[2];
    int         m_h[2], m_t[2], m_u[2], m_k[2];
    bit         m_err[2];
    bit         accepted0;
    logic [6:0] enc_tab[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

    function automatic logic [6:0] enc(input int d);
        if (d > 9) return 7'b1111001;
        return enc_tab[d];
    endfunction

    function automatic bit model_ready(input int i);
        int frame;
        frame = 3 * m_div[i];
        return !m_scan[i] || ((m_k[i] % frame) == frame - 1);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] s, input logic c,
                         input logic b, input logic r);
        logic [6:0] e_seg[2];
        logic [2:0] e_an[2];
        logic       e_err[2];
        logic       e_rdy;
        logic       rdy_obs;
        bit         xf, vis;
        int         slot, dig, nt, nu;
        @(negedge clk);
        in_valid = v; sum_in = s; cout_in = c; blank = b; rst = r;
        #1;
        accepted0 = 1'b0;
        nt = int'(s[7:4]);
        nu = int'(s[3:0]);
        for (int i = 0; i < 2; i++) begin
            e_rdy   = r || model_ready(i);
            rdy_obs = (i == 0) ? rdy0 : rdy1;
            chk($sformatf("in_ready%0d", i), {7'b0, rdy_obs}, {7'b0, e_rdy});
            xf = v && e_rdy && !r && !b;
            e_an[i]  = 3'b000;
            e_seg[i] = 7'b0000000;
            if (!(r || b) && m_scan[i]) begin
                slot = (m_k[i] % (3 * m_div[i])) / m_div[i];
                case (slot)
                    0:       begin vis = 1'b1;                          dig = m_u[i]; end
                    1:       begin vis = (m_h[i] != 0) || (m_t[i] != 0); dig = m_t[i]; end
                    default: begin vis = (m_h[i] != 0);                 dig = m_h[i]; end
                endcase
                if (vis) begin
                    e_an[i]  = 3'(1 << slot);
                    e_seg[i] = enc(dig);
                end
            end
            if (m_al[i]) e_seg[i] = ~e_seg[i];
            e_err[i] = (r || b) ? 1'b0 : (xf ? ((nt > 9) || (nu > 9)) : m_err[i]);
            if (r || b) begin
                m_scan[i] = 1'b0;
                m_err[i]  = 1'b0;
            end else if (xf) begin
                m_h[i] = int'(c); m_t[i] = nt; m_u[i] = nu;
                m_scan[i] = 1'b1; m_k[i] = 0; m_err[i] = e_err[i];
                if (i == 0) accepted0 = 1'b1;
            end else if (m_scan[i]) begin
                m_k[i]++;
            end
        end
        @(posedge clk);
        #1;
        chk("seg0", {1'b0, seg0}, {1'b0, e_seg[0]});
        chk("an0",  {5'b0, an0},  {5'b0, e_an[0]});
        chk("err0", {7'b0, err0}, {7'b0, e_err[0]});
        chk("seg1", {1'b0, seg1}, {1'b0, e_seg[1]});
        chk("an1",  {5'b0, an1},  {5'b0, e_an[1]});
        chk("err1", {7'b0, err1}, {7'b0, e_err[1]});
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Hold in_valid until instance 0 accepts (stall behaviour is checked each cycle)
    task automatic send(input logic [7:0] s, input logic c);
        int n;
        n = 0;
        accepted0 = 1'b0;
        while (!accepted0 && n < 40) begin
            cycle(1'b1, s, c, 1'b0, 1'b0);
            n++;
        end
        if (!accepted0) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: observed no capture of %h expected capture within 40 cycles", s);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; sum_in = '0; cout_in = 1'b0; blank = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_scan[i] = 1'b0; m_h[i] = 0; m_t[i] = 0; m_u[i] = 0; m_k[i] = 0; m_err[i] = 1'b0;
        end

        // Reset
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Full three-digit value
        send(8'h99, 1'b1);
        idle(30);

        // Leading-zero blanking of tens and hundreds; sent from mid-frame
        send(8'h02, 1'b0);
        idle(26);

        // Stall from mid-frame
        idle(3);
        send(8'h52, 1'b0);
        idle(14);

        // Non-BCD units nibble
        send(8'h3A, 1'b0);
        idle(14);

        // Blank mid-scan
        idle(5);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Reset mid-scan
        send(8'h45, 1'b1);
        idle(6);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Blank coinciding with a transfer at frame end
        send(8'h13, 1'b0);
        n = 0;
        while (!model_ready(0) && n < 20) begin
            idle(1);
            n++;
        end
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Single-digit value on the active-low, fast-scan instance
        send(8'h08, 1'b0);
        idle(10);

        // Randomized traffic
        for (int j = 0; j < 400; j++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each digit slot is held; legal range is 1 or greater.
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 0: 1 inverts every seg bit, including blank.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: sum_in/cout_in hold a result to display.
REQ-006 SHALL have port in_ready, output, 1: block accepts a result this cycle.
REQ-007 SHALL have port sum_in, input, 8: packed 2-digit BCD sum ([7:4] tens, [3:0] units), as produced by the upstream BCD adder.
REQ-008 SHALL have port cout_in, input, 1: BCD carry from the adder, which is the hundreds digit.
REQ-009 SHALL have port seg, output, 7: segment pattern, bit order gfedcba.
REQ-010 SHALL have port an, output, 3: one-hot digit enable; bit0 is units, bit1 tens, bit2 hundreds.
REQ-011 SHALL have port err, output, 1: held value contains a non-BCD nibble (value greater than 9).
REQ-012 SHALL have port blank, input, 1: synchronous request to clear the display and return to IDLE.

Function
REQ-013 SHALL implement two states, IDLE and SCAN; a transfer occurs when in_valid and in_ready are both high on a posedge clk.
REQ-014 In IDLE, in_ready SHALL be 1, an SHALL be 000, seg SHALL be blank, and a transfer SHALL move the block to SCAN.
REQ-015 In SCAN, in_ready SHALL be 1 only in the last cycle of the hundreds slot (frame end) and 0 otherwise.
REQ-016 A transfer SHALL capture {cout_in, sum_in} into the hold register; from the next cycle the units slot starts, with the prescaler at 0.
REQ-017 Slot order SHALL be units, tens, hundreds, then wrap to units; each slot lasts exactly SCAN_DIV cycles.
REQ-018 seg, an and err SHALL be registered outputs: one cycle of latency from state/counter to pins.
REQ-019 Leading-zero blanking: the hundreds digit SHALL be blank when carry=0; the tens digit SHALL be blank when carry=0 and tens=0; the units digit SHALL always be shown.
REQ-020 For a blanked slot, the an bit SHALL be 0 and seg SHALL be blank; the slot still consumes SCAN_DIV cycles.
REQ-021 Digit encodings (active-high) SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, blank=0000000.
REQ-022 A nibble with value greater than 9 SHALL display E=1111001; err SHALL be 1 while the held value has any such nibble and SHALL update on each capture.
REQ-023 When in_valid is high outside frame end, the input SHALL NOT be captured; the upstream holds its data (stall).
REQ-024 When blank is high, the next state SHALL be IDLE and err SHALL be cleared; blank SHALL take priority over a simultaneous transfer, which SHALL NOT capture.
REQ-025 When SCAN_DIV=1, each slot SHALL last one cycle and in_ready SHALL be high every third cycle.

Reset
REQ-026 When rst is high, the next state SHALL be IDLE, the prescaler and slot counter SHALL be 0, the hold register SHALL be 0, an SHALL be 000, seg SHALL be blank, err SHALL be 0 and in_ready SHALL be 1.
REQ-027 rst SHALL take priority over blank and over a transfer; a reset mid-frame SHALL abandon the frame immediately.

Structure
REQ-028 Package bcd_pkg SHALL hold the state enum, NUM_DIGITS=3, the SEG_* digit constants, SEG_BLANK and SEG_E.
REQ-029 SHALL instantiate one combinational sub-module, bcd_to_seg7 (4-bit nibble plus blank-enable in, 7-bit gfedcba out).
REQ-030 SEG_ACTIVE_LOW inversion SHALL be applied once, at the output register.

Verification (SCAN_DIV=4 unless stated)
REQ-031 Reset, then transfer sum_in=8'h99, cout_in=1 -> repeating frame: an=001 with seg 1101111 for 4 cycles, an=010 with 1101111 for 4 cycles, an=100 with 0000110 for 4 cycles; err=0.
REQ-032 Transfer sum_in=8'h02, cout_in=0 -> an=001 with seg 1011011 for 4 cycles, then an=000 with blank for 8 cycles, then repeat.
REQ-033 Hold in_valid with sum_in=8'h52 from mid-frame -> in_ready=0 until frame end; capture at frame end; units slot shows 1011011 on the following cycle.
REQ-034 Transfer sum_in=8'h3A, cout_in=0 -> units slot shows 1111001, tens slot shows 1001111, err=1.
REQ-035 Assert blank mid-SCAN, and separately rst mid-SCAN -> IDLE next cycle: an=000, seg blank, in_ready=1, err=0; blank together with in_valid at frame end -> no capture.
REQ-036 Set SEG_ACTIVE_LOW=1, SCAN_DIV=1, transfer sum_in=8'h08 -> seg=0000000 on the units slot, 1111111 on blanked slots, and in_ready high every 3rd cycle.
